qpp_addr_gen: RTL
=================

# qpp_addr_gen

Recursive QPP (quadratic permutation polynomial) address generator for the LTE turbo interleaver. On a start pulse it latches block length K and coefficients f1/f2, then streams pi(i) = (f1·i + f2·i²) mod K for i = 0..K-1 over a valid/ready handshake. It uses only modular additions, never multiplies. It sits directly upstream of the interleaver's registered address/data pipeline, which consumes one address per accepted beat.

## Interface
- AW, 13: address/length width; covers K ≤ 6144.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- k_len  in  AW  block length K; sampled with start; 2 ≤ K < 2^AW.
- f1  in  AW  linear coefficient; sampled with start; f1 < K.
- f2  in  AW  quadratic coefficient; sampled with start; f2 < K.
- addr_out  out  AW  current pi(i), registered.
- addr_vld  out  1  addr_out valid.
- addr_rdy  in  1  downstream accepts addr_out.
- busy  out  1  high from INIT through the last handshake.
- done  out  1  one-cycle pulse after the last address is accepted.

## Operation
- Recursion, with all terms kept in [0, K):
  - pi(0) = 0.
  - g(0) = (f1 + f2) mod K.
  - inc = (2·f2) mod K.
  - pi(i+1) = (pi(i) + g(i)) mod K.
  - g(i+1) = (g(i) + inc) mod K.
- Modular add rule: s = a + b at AW+1 bits. Result is s − K if s ≥ K, else s. Valid only because a, b < K; callers must meet the f1 < K and f2 < K constraints. Out-of-range inputs give undefined addresses, with no error flag.
- FSM states and transitions:
  - IDLE: start=1 → INIT. Latch K, f1, f2. Clear pi, idx.
  - INIT: compute g(0) and inc into registers → RUN, unconditionally.
  - RUN: addr_vld=1. A handshake (vld & rdy) advances idx, pi and g. A handshake with idx == K−1 → DONE.
  - DONE: done=1, addr_vld=0 → IDLE, unconditionally.
- start outside IDLE is ignored. Coefficients are not re-sampled mid-block.
- addr_rdy low in RUN holds addr_out, idx, pi and g stable; no beat is dropped or repeated.
- idx is an AW-bit counter 0..K−1 and never wraps past K−1.
- Reset values, any state, including mid-block: state=IDLE, addr_out=0, addr_vld=0, busy=0, done=0, and all internal registers 0. The block resumes only on a new start.

## Timing
- start sampled at edge t. INIT occupies t..t+1. addr_vld=1 with addr_out=0 from edge t+2.
- With addr_rdy held high, one address per clock. The last address is presented at edge t+K+1, and done pulses at edge t+K+2.
- busy rises at edge t+1 and falls at edge t+K+2, the same edge at which done rises.
- Earliest next start is sampled at edge t+K+3, when the block is back in IDLE.
- addr_vld must never drop without a handshake while in RUN.

## Structure
- Shared package qpp_pkg holds:
  - state encoding constants (IDLE, INIT, RUN, DONE);
  - AW default;
  - K_MAX = 6144.
- One sub-module, qpp_mod_add (a, b, K → (a+b) mod K, combinational), instantiated three times: pi update, g update, and INIT precompute.
- Precompute reuses the instances: (f1+f2) mod K uses qpp_mod_add(f1, f2); inc uses qpp_mod_add(f2, f2).
- All state lives in async-reset flops in the top module.

## Test plan
- K=40, f1=3, f2=10, addr_rdy=1 → first four addresses 0, 13, 6, 19. Exactly 40 beats, all distinct. done one cycle after the 40th beat.
- K=6144, f1=263, f2=480 → first addresses 0, 743, 2446. Last address 217. All 6144 distinct, compared against a golden multiply-based model.
- K=40 block with addr_rdy randomly deasserted 50% of cycles → identical sequence to the no-stall case. addr_out stable while vld & !rdy.
- start re-pulsed during RUN with different f1/f2 → ignored; the sequence continues with the original coefficients.
- rst_n asserted mid-block at idx=17 → outputs 0 immediately (asynchronous). After release, no activity until a new start; the next block restarts from pi(0)=0.
- K=2, f1=1, f2=0 → sequence 0, 1. done at edge t+4, busy high for exactly 3 cycles.

Source files
------------

// File: rtl/qpp_pkg.sv
// Shared definitions for the QPP turbo-interleaver address generator:
// default widths, largest supported block length and the FSM encoding.
package qpp_pkg;

  localparam int AW_DEFAULT = 13;
  localparam int K_MAX      = 6144;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/qpp_mod_add.sv
// Combinational modular adder: sum = (a + b) mod k.
// Holds only when both operands are already reduced below k.
module qpp_mod_add #(
  parameter int AW = 13
) (
  input  logic [AW-1:0] a_i,
  input  logic [AW-1:0] b_i,
  input  logic [AW-1:0] k_i,
  output logic [AW-1:0] sum_o
);

  logic [AW:0] s;

  // One extra bit keeps the carry so a single conditional subtract reduces it.
  assign s     = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o = (s >= {1'b0, k_i}) ? AW'(s - {1'b0, k_i}) : AW'(s);

endmodule

// File: rtl/qpp_addr_gen.sv
// Recursive QPP address generator: streams pi(i) = (f1*i + f2*i^2) mod K
// for i = 0..K-1 using only modular additions, over a valid/ready handshake.
module qpp_addr_gen
  import qpp_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] k_len,
  input  logic [AW-1:0] f1,
  input  logic [AW-1:0] f2,
  output logic [AW-1:0] addr_out,
  output logic          addr_vld,
  input  logic          addr_rdy,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic          start_q, start_d;
  logic [AW-1:0] k_q, k_d, f1_q, f1_d, f2_q, f2_d;
  logic [AW-1:0] pi_q, pi_d, g_q, g_d, inc_q, inc_d, idx_q, idx_d;
  logic [AW-1:0] pi_sum, g_sum, inc_sum, g_add_a, g_add_b;
  logic          in_init;

  // The g adder doubles as the g(0) = f1 + f2 precompute while in INIT.
  assign in_init = (state_q == S_INIT);
  assign g_add_a = in_init ? f1_q : g_q;
  assign g_add_b = in_init ? f2_q : inc_q;

  qpp_mod_add #(.AW(AW)) u_pi_add (
    .a_i(pi_q), .b_i(g_q), .k_i(k_q), .sum_o(pi_sum)
  );

  qpp_mod_add #(.AW(AW)) u_g_add (
    .a_i(g_add_a), .b_i(g_add_b), .k_i(k_q), .sum_o(g_sum)
  );

  qpp_mod_add #(.AW(AW)) u_inc_add (
    .a_i(f2_q), .b_i(f2_q), .k_i(k_q), .sum_o(inc_sum)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d = state_q;
    start_d = 1'b0;
    k_d     = k_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    pi_d    = pi_q;
    g_d     = g_q;
    inc_d   = inc_q;
    idx_d   = idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d = S_INIT;
          pi_d    = '0;
          idx_d   = '0;
        end
      end
      S_INIT: begin
        g_d     = g_sum;
        inc_d   = inc_sum;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (addr_rdy) begin
          if (idx_q == k_q - AW'(1)) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + AW'(1);
            pi_d  = pi_sum;
            g_d   = g_sum;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A request is captured only when the FSM will be idle to act on it next cycle.
    if (start && (state_d == S_IDLE)) begin
      start_d = 1'b1;
      k_d     = k_len;
      f1_d    = f1;
      f2_d    = f2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      k_q     <= '0;
      f1_q    <= '0;
      f2_q    <= '0;
      pi_q    <= '0;
      g_q     <= '0;
      inc_q   <= '0;
      idx_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      start_q <= start_d;
      k_q     <= k_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      pi_q    <= pi_d;
      g_q     <= g_d;
      inc_q   <= inc_d;
      idx_q   <= idx_d;
    end
  end

  assign addr_out = pi_q;
  assign addr_vld = (state_q == S_RUN);
  assign busy     = (state_q == S_INIT) || (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

endmodule
